rd_tracker: RTL and testbench
=============================

Name: rd_tracker

Overview:
- Producer side of operand forwarding in the 5-stage RV32I pipeline.
- Carries each instruction's destination register id, its write-back enable and its load flag from ID through the EX, MA and WB pipeline registers.
- Detects load-use hazards at ID and inserts a one-cycle bubble into EX.
- Counts load-use stall cycles for performance monitoring.
- Its EX/MA/WB outputs are the rd_adr_*/wbk_rd_reg_*/cmd_ld_ex inputs that the forwarding comparators consume.

Parameters:
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst_rd_id  input  5  destination register of the instruction in ID.
- inst_rd_valid  input  1  instruction in ID writes rd.
- cmd_ld_id  input  1  instruction in ID is a load.
- inst_rs1_id  input  5  rs1 of the instruction in ID.
- inst_rs1_valid  input  1  instruction in ID reads rs1.
- inst_rs2_id  input  5  rs2 of the instruction in ID.
- inst_rs2_valid  input  1  instruction in ID reads rs2.
- stall  input  1  external pipeline freeze (memory wait).
- rst_pipe  input  1  pipeline flush (taken branch/jump resolved in EX).
- cnt_clr  input  1  synchronous clear of the stall counter.
- rd_adr_ex  output  5  rd id held in the EX stage.
- wbk_rd_reg_ex  output  1  EX stage writes rd.
- cmd_ld_ex  output  1  EX stage holds a load.
- rd_adr_ma  output  5  rd id held in the MA stage.
- wbk_rd_reg_ma  output  1  MA stage writes rd.
- rd_adr_wb  output  5  rd id held in the WB stage.
- wbk_rd_reg_wb  output  1  WB stage writes rd.
- stall_ld  output  1  combinational load-use stall request to IF/ID.
- bubble_ex  output  1  registered; EX currently holds an inserted load-use bubble.
- ld_stall_cnt  output  CNT_W  load-use stall cycle count.

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0. This covers all rd_adr_*, wbk_*, cmd_ld_ex, bubble_ex and ld_stall_cnt.
- x0 suppression: wbk_in = inst_rd_valid & (inst_rd_id != 0). An instruction writing x0 never reaches any stage with wbk set.
- Bubble definition: rd_adr = 0, wbk = 0, cmd_ld = 0.
- Hazard: hazard_ld = cmd_ld_ex & wbk_rd_reg_ex & ((inst_rs1_valid & inst_rs1_id == rd_adr_ex) | (inst_rs2_valid & inst_rs2_id == rd_adr_ex)).
- stall_ld = hazard_ld & ~rst_pipe. It is purely combinational, with zero-cycle latency.
- Each clock edge applies the first matching case, in priority order:
  1. rst_pipe=1: EX <= bubble; MA <= EX; WB <= MA; bubble_ex <= 0. rst_pipe overrides stall.
  2. stall=1: all stages and bubble_ex hold. The counter holds.
  3. stall_ld=1: EX <= bubble; MA <= EX; WB <= MA; bubble_ex <= 1. The ID instruction is held upstream.
  4. Otherwise: EX <= {inst_rd_id (0 if ~wbk_in), wbk_in, cmd_ld_id & wbk_in}; MA <= EX; WB <= MA; bubble_ex <= 0.
- Load-use resolves in exactly one bubble. After the bubble, the load sits in MA and the forwarding MA path supplies the data. hazard_ld therefore cannot be true on two consecutive advancing cycles for the same ID instruction.
- Load ordering: a load with rd=x0 is tracked as non-writing (cmd_ld_ex=0) and never stalls.
- Stall interaction: if stall and hazard_ld are both 1, stall_ld is still asserted. No bubble is inserted until stall deasserts. The counter does not increment during stall.
- Counter:
  - cnt_clr sets it to 0 and has priority over increment.
  - Otherwise it increments by 1 on each edge with stall_ld & ~stall.
  - It saturates at all ones (2^CNT_W - 1) and never wraps.
- Reset asserted mid-stall or mid-bubble: all state returns to 0 immediately. There is no residual stall_ld, because cmd_ld_ex=0.

Test Plan:
- Reset/x0: hold rst_n=0 with random inputs, then release, then issue rd=0 with valid=1 -> all outputs 0. wbk_rd_reg_ex stays 0 one cycle after x0 issue.
- Pipeline flow: issue rd=5, 6, 7 (valid, non-load) on consecutive cycles -> cycle 3 shows rd_adr_wb=5, rd_adr_ma=6, rd_adr_ex=7, with all wbk=1.
- Load-use: load rd=3, then ID rs2=3 valid -> stall_ld=1 for exactly one cycle. Next cycle: bubble_ex=1, wbk_rd_reg_ex=0, rd_adr_ma=3, ld_stall_cnt=1, stall_ld=0.
- Stall during hazard: load rd=4 in EX, ID rs1=4, stall=1 for 3 cycles -> stages frozen, stall_ld=1 throughout, counter stays 0. After stall drops: one bubble, counter=1.
- Flush: rst_pipe=1 with load rd=8 in EX and hazard present -> stall_ld=0. Next cycle: EX bubble, rd_adr_ma=8, cmd_ld_ex=0, counter unchanged.
- Counter saturation/clear: with CNT_W=2, force 5 load-use stalls -> ld_stall_cnt=3. Assert cnt_clr together with a stall_ld cycle -> ld_stall_cnt=0.

Source files
------------

// File: rtl/rd_tracker_if.sv
// rd_tracker_if: ID-stage request signals and EX/MA/WB destination tracking outputs of rd_tracker.
// master: drives the ID instruction fields plus stall/rst_pipe/cnt_clr and observes the tracked stages.
// slave : the tracker itself.
interface rd_tracker_if #(parameter int CNT_W = 16);
  logic [4:0]       inst_rd_id;
  logic             inst_rd_valid;
  logic             cmd_ld_id;
  logic [4:0]       inst_rs1_id;
  logic             inst_rs1_valid;
  logic [4:0]       inst_rs2_id;
  logic             inst_rs2_valid;
  logic             stall;
  logic             rst_pipe;
  logic             cnt_clr;
  logic [4:0]       rd_adr_ex;
  logic             wbk_rd_reg_ex;
  logic             cmd_ld_ex;
  logic [4:0]       rd_adr_ma;
  logic             wbk_rd_reg_ma;
  logic [4:0]       rd_adr_wb;
  logic             wbk_rd_reg_wb;
  logic             stall_ld;
  logic             bubble_ex;
  logic [CNT_W-1:0] ld_stall_cnt;
  modport master (
    output inst_rd_id, inst_rd_valid, cmd_ld_id, inst_rs1_id, inst_rs1_valid,
           inst_rs2_id, inst_rs2_valid, stall, rst_pipe, cnt_clr,
    input  rd_adr_ex, wbk_rd_reg_ex, cmd_ld_ex, rd_adr_ma, wbk_rd_reg_ma,
           rd_adr_wb, wbk_rd_reg_wb, stall_ld, bubble_ex, ld_stall_cnt
  );
  modport slave (
    input  inst_rd_id, inst_rd_valid, cmd_ld_id, inst_rs1_id, inst_rs1_valid,
           inst_rs2_id, inst_rs2_valid, stall, rst_pipe, cnt_clr,
    output rd_adr_ex, wbk_rd_reg_ex, cmd_ld_ex, rd_adr_ma, wbk_rd_reg_ma,
           rd_adr_wb, wbk_rd_reg_wb, stall_ld, bubble_ex, ld_stall_cnt
  );
endinterface

// File: rtl/rd_tracker.sv
// rd_tracker: carries rd/write-back/load flags through EX, MA, WB, detects load-use hazards and counts stall cycles.
// clk, rst_n (async, active-low) plain ports; everything else on bus (rd_tracker_if.slave):
//   ID inputs inst_rd_*/cmd_ld_id/inst_rs*_*, controls stall/rst_pipe/cnt_clr,
//   outputs rd_adr_*/wbk_rd_reg_*/cmd_ld_ex, stall_ld (combinational), bubble_ex, ld_stall_cnt.
module rd_tracker #(parameter int CNT_W = 16) (
  input logic         clk,
  input logic         rst_n,
  rd_tracker_if.slave bus
);
  logic [4:0]       rd_ex_q, rd_ex_d, rd_ma_q, rd_ma_d, rd_wb_q, rd_wb_d;
  logic             wbk_ex_q, wbk_ex_d, wbk_ma_q, wbk_ma_d, wbk_wb_q, wbk_wb_d;
  logic             ld_ex_q, ld_ex_d, bub_q, bub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wbk_in, hazard_ld, stall_ld, adv, ins_bub;
  // writes to x0 are dropped at entry so no stage ever advertises them for forwarding
  assign wbk_in    = bus.inst_rd_valid & (bus.inst_rd_id != 5'd0);
  assign hazard_ld = ld_ex_q & wbk_ex_q &
                     ((bus.inst_rs1_valid & (bus.inst_rs1_id == rd_ex_q)) |
                      (bus.inst_rs2_valid & (bus.inst_rs2_id == rd_ex_q)));
  assign stall_ld  = hazard_ld & ~bus.rst_pipe;
  // a flush advances the pipe even under an external freeze
  assign adv       = bus.rst_pipe | ~bus.stall;
  assign ins_bub   = bus.rst_pipe | stall_ld;
  always_comb begin
    rd_ex_d  = adv ? ((ins_bub | ~wbk_in) ? 5'd0 : bus.inst_rd_id) : rd_ex_q;
    wbk_ex_d = adv ? (~ins_bub & wbk_in) : wbk_ex_q;
    ld_ex_d  = adv ? (~ins_bub & wbk_in & bus.cmd_ld_id) : ld_ex_q;
    rd_ma_d  = adv ? rd_ex_q : rd_ma_q;
    wbk_ma_d = adv ? wbk_ex_q : wbk_ma_q;
    rd_wb_d  = adv ? rd_ma_q : rd_wb_q;
    wbk_wb_d = adv ? wbk_ma_q : wbk_wb_q;
    bub_d    = adv ? stall_ld : bub_q;
    cnt_d    = bus.cnt_clr ? '0 : (stall_ld & ~bus.stall & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ex_q  <= '0;
      wbk_ex_q <= 1'b0;
      ld_ex_q  <= 1'b0;
      rd_ma_q  <= '0;
      wbk_ma_q <= 1'b0;
      rd_wb_q  <= '0;
      wbk_wb_q <= 1'b0;
      bub_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rd_ex_q  <= rd_ex_d;
      wbk_ex_q <= wbk_ex_d;
      ld_ex_q  <= ld_ex_d;
      rd_ma_q  <= rd_ma_d;
      wbk_ma_q <= wbk_ma_d;
      rd_wb_q  <= rd_wb_d;
      wbk_wb_q <= wbk_wb_d;
      bub_q    <= bub_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.rd_adr_ex     = rd_ex_q;
  assign bus.wbk_rd_reg_ex = wbk_ex_q;
  assign bus.cmd_ld_ex     = ld_ex_q;
  assign bus.rd_adr_ma     = rd_ma_q;
  assign bus.wbk_rd_reg_ma = wbk_ma_q;
  assign bus.rd_adr_wb     = rd_wb_q;
  assign bus.wbk_rd_reg_wb = wbk_wb_q;
  assign bus.stall_ld      = stall_ld;
  assign bus.bubble_ex     = bub_q;
  assign bus.ld_stall_cnt  = cnt_q;
endmodule

// File: tb/tb_rd_tracker.sv
// tb_rd_tracker: directed stimulus, per-cycle model comparison and literal checks for rd_tracker.
module tb_rd_tracker;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    logic [4:0] rd;
    logic       w;
    logic       ld;
  } st_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  st_t  m [3];
  logic m_bub;
  int   m_cnt;
  rd_tracker_if #(.CNT_W(CW)) bus ();
  rd_tracker #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic m_hz();
    logic uses;
    uses = (bus.inst_rs1_valid && bus.inst_rs1_id == m[0].rd) ||
           (bus.inst_rs2_valid && bus.inst_rs2_id == m[0].rd);
    return m[0].ld && m[0].w && uses && !bus.rst_pipe;
  endfunction
  function automatic st_t entry();
    st_t s;
    s.w  = bus.inst_rd_valid && bus.inst_rd_id != 0;
    s.rd = s.w ? bus.inst_rd_id : 5'd0;
    s.ld = s.w && bus.cmd_ld_id;
    return s;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= '{5'd0, 1'b0, 1'b0};
      m_bub <= 1'b0;
      m_cnt <= 0;
    end else begin
      if (bus.cnt_clr) m_cnt <= 0;
      else if (m_hz() && !bus.stall) m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (bus.rst_pipe || !bus.stall) begin
        m[2]  <= m[1];
        m[1]  <= m[0];
        m[0]  <= (bus.rst_pipe || m_hz()) ? '{5'd0, 1'b0, 1'b0} : entry();
        m_bub <= m_hz();
      end
    end
  end
  always @(negedge clk) begin
    chk("ex_rd", 32'(bus.rd_adr_ex), 32'(m[0].rd));
    chk("ex_wbk", 32'(bus.wbk_rd_reg_ex), 32'(m[0].w));
    chk("ex_ld", 32'(bus.cmd_ld_ex), 32'(m[0].ld));
    chk("ma_rd", 32'(bus.rd_adr_ma), 32'(m[1].rd));
    chk("ma_wbk", 32'(bus.wbk_rd_reg_ma), 32'(m[1].w));
    chk("wb_rd", 32'(bus.rd_adr_wb), 32'(m[2].rd));
    chk("wb_wbk", 32'(bus.wbk_rd_reg_wb), 32'(m[2].w));
    chk("stall_ld", 32'(bus.stall_ld), 32'(m_hz()));
    chk("bubble", 32'(bus.bubble_ex), 32'(m_bub));
    chk("cnt", 32'(bus.ld_stall_cnt), 32'(m_cnt));
  end
  task automatic idle();
    bus.inst_rd_id = 0; bus.inst_rd_valid = 0; bus.cmd_ld_id = 0;
    bus.inst_rs1_id = 0; bus.inst_rs1_valid = 0;
    bus.inst_rs2_id = 0; bus.inst_rs2_valid = 0;
    bus.stall = 0; bus.rst_pipe = 0; bus.cnt_clr = 0;
  endtask
  task automatic set_id(input logic [4:0] rd, input logic v, input logic ld,
                        input logic [4:0] r1, input logic r1v, input logic [4:0] r2, input logic r2v);
    bus.inst_rd_id = rd; bus.inst_rd_valid = v; bus.cmd_ld_id = ld;
    bus.inst_rs1_id = r1; bus.inst_rs1_valid = r1v;
    bus.inst_rs2_id = r2; bus.inst_rs2_valid = r2v;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    for (int i = 0; i < 4; i++) begin
      set_id(5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      bus.stall = 1'($urandom); bus.rst_pipe = 1'($urandom); bus.cnt_clr = 1'($urandom);
      tick();
    end
    chk("rst_ex_rd", 32'(bus.rd_adr_ex), 0);
    chk("rst_wbk_wb", 32'(bus.wbk_rd_reg_wb), 0);
    chk("rst_cnt", 32'(bus.ld_stall_cnt), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_id(0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("x0_wbk_ex", 32'(bus.wbk_rd_reg_ex), 0);
    chk("x0_rd_ex", 32'(bus.rd_adr_ex), 0);
    set_id(5, 1, 0, 0, 0, 0, 0); tick();
    set_id(6, 1, 0, 0, 0, 0, 0); tick();
    set_id(7, 1, 0, 0, 0, 0, 0); tick();
    chk("flow_wb", 32'(bus.rd_adr_wb), 5);
    chk("flow_ma", 32'(bus.rd_adr_ma), 6);
    chk("flow_ex", 32'(bus.rd_adr_ex), 7);
    chk("flow_wbk", 32'({bus.wbk_rd_reg_wb, bus.wbk_rd_reg_ma, bus.wbk_rd_reg_ex}), 7);
    idle(); tick(); tick(); tick();
    set_id(3, 1, 1, 0, 0, 0, 0); tick();
    set_id(9, 1, 0, 0, 0, 3, 1); #1;
    chk("lu_stall", 32'(bus.stall_ld), 1);
    tick();
    chk("lu_bubble", 32'(bus.bubble_ex), 1);
    chk("lu_wbk_ex", 32'(bus.wbk_rd_reg_ex), 0);
    chk("lu_ma_rd", 32'(bus.rd_adr_ma), 3);
    chk("lu_cnt", 32'(bus.ld_stall_cnt), 1);
    chk("lu_stall_off", 32'(bus.stall_ld), 0);
    tick();
    chk("lu_issue", 32'(bus.rd_adr_ex), 9);
    idle(); bus.cnt_clr = 1; tick();
    idle();
    set_id(4, 1, 1, 0, 0, 0, 0); tick();
    set_id(10, 1, 0, 4, 1, 0, 0); bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_ex_rd", 32'(bus.rd_adr_ex), 4);
      chk("st_stall_ld", 32'(bus.stall_ld), 1);
      chk("st_cnt", 32'(bus.ld_stall_cnt), 0);
    end
    bus.stall = 0; tick();
    chk("st_bubble", 32'(bus.bubble_ex), 1);
    chk("st_cnt1", 32'(bus.ld_stall_cnt), 1);
    idle(); tick();
    set_id(8, 1, 1, 0, 0, 0, 0); tick();
    set_id(11, 1, 0, 8, 1, 0, 0); bus.rst_pipe = 1; #1;
    chk("fl_stall_ld", 32'(bus.stall_ld), 0);
    tick();
    chk("fl_ex_rd", 32'(bus.rd_adr_ex), 0);
    chk("fl_ma_rd", 32'(bus.rd_adr_ma), 8);
    chk("fl_ld_ex", 32'(bus.cmd_ld_ex), 0);
    chk("fl_cnt", 32'(bus.ld_stall_cnt), 1);
    idle(); bus.cnt_clr = 1; tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      set_id(5'(i + 1), 1, 1, 0, 0, 0, 0); tick();
      set_id(20, 1, 0, 5'(i + 1), 1, 0, 0); tick();
      idle(); tick();
    end
    chk("sat_cnt", 32'(bus.ld_stall_cnt), 3);
    set_id(12, 1, 1, 0, 0, 0, 0); tick();
    set_id(13, 1, 0, 0, 0, 12, 1); bus.cnt_clr = 1; #1;
    chk("clr_stall_ld", 32'(bus.stall_ld), 1);
    tick();
    chk("clr_cnt", 32'(bus.ld_stall_cnt), 0);
    chk("clr_bubble", 32'(bus.bubble_ex), 1);
    idle(); tick();
    set_id(0, 1, 1, 0, 0, 0, 0); tick();
    set_id(14, 1, 0, 0, 1, 0, 1); #1;
    chk("x0ld_ld_ex", 32'(bus.cmd_ld_ex), 0);
    chk("x0ld_stall", 32'(bus.stall_ld), 0);
    idle(); tick();
    set_id(2, 1, 1, 0, 0, 0, 0); tick();
    set_id(15, 1, 0, 2, 1, 0, 0); bus.stall = 1; #1;
    chk("rs_stall_pre", 32'(bus.stall_ld), 1);
    rst_n = 1'b0; #1;
    chk("rs_ex_rd", 32'(bus.rd_adr_ex), 0);
    chk("rs_ld_ex", 32'(bus.cmd_ld_ex), 0);
    chk("rs_stall_ld", 32'(bus.stall_ld), 0);
    chk("rs_ma_rd", 32'(bus.rd_adr_ma), 0);
    idle(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
